// File: rtl/frame_sync_ctrl_pkg.sv
// Shared types and constants for the frame synchroniser.
// Holds the FSM state type, the default sync pattern and the counter widths.
package frame_sync_ctrl_pkg;

   typedef enum logic {
      HUNT    = 1'b0,
      PAYLOAD = 1'b1
   } fsc_state_e;

   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hEB90_146F;
   localparam int unsigned BYTE_CNT_W        = 16;
   localparam int unsigned IDLE_CNT_W        = 16;

endpackage

// File: rtl/frame_idle_timer.sv
// Idle watchdog for the payload phase: counts clk cycles since the last bit strobe
// and flags the cycle in which the count has reached the terminal value.
module frame_idle_timer
   import frame_sync_ctrl_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = 65535
)(
   input  logic clk,
   input  logic nRST,
   input  logic active_i,
   input  logic kick_i,
   output logic expired_o
);

   localparam logic [IDLE_CNT_W-1:0] TERM_CNT = IDLE_CNT_W'(IDLE_TIMEOUT);

   logic [IDLE_CNT_W-1:0] idle_q, idle_d;

   // A strobe in the terminal cycle wins over the timeout and restarts the count.
   always_comb begin
      idle_d    = idle_q;
      expired_o = 1'b0;
      if (!active_i || kick_i) begin
         idle_d = '0;
      end else if (idle_q == TERM_CNT) begin
         expired_o = 1'b1;
         idle_d    = '0;
      end else begin
         idle_d = idle_q + IDLE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Serial frame synchroniser: hunts for a 32-bit sync word, then assembles
// FRAME_BYTES payload bytes MSB-first behind a single-entry valid/ready holding slot.
module frame_sync_ctrl
   import frame_sync_ctrl_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
   parameter int unsigned FRAME_BYTES  = 1024,
   parameter int unsigned IDLE_TIMEOUT = 65535
)(
   input  logic       clk,
   input  logic       nRST,
   input  logic       enable,
   input  logic       bit_in,
   input  logic       bit_en,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       sof,
   output logic       eof,
   output logic       locked,
   output logic       overflow,
   output logic       timeout_err
);

   localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(FRAME_BYTES - 1);

   fsc_state_e            state_q, state_d;
   // Older 31 bits of the window; the incoming bit completes the 32-bit compare.
   logic [30:0]           sr_q, sr_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]            byte_q, byte_d;
   logic                  valid_q, valid_d;
   logic                  sof_q, sof_d;
   logic                  eof_q, eof_d;
   logic                  ovf_q, ovf_d;
   logic                  tmo_q, tmo_d;
   logic [31:0]           shifted;
   logic                  idle_expired;

   frame_idle_timer #(
      .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) u_idle_timer (
      .clk       (clk),
      .nRST      (nRST),
      .active_i  (enable && (state_q == PAYLOAD)),
      .kick_i    (bit_en),
      .expired_o (idle_expired)
   );

   assign shifted = {sr_q, bit_in};

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      byte_d     = byte_q;
      valid_d    = valid_q;
      sof_d      = sof_q;
      eof_d      = eof_q;
      ovf_d      = ovf_q;
      tmo_d      = 1'b0;

      if (valid_q && byte_ready) begin
         valid_d = 1'b0;
         sof_d   = 1'b0;
         eof_d   = 1'b0;
      end

      if (!enable) begin
         state_d    = HUNT;
         sr_d       = '0;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         valid_d    = 1'b0;
         sof_d      = 1'b0;
         eof_d      = 1'b0;
         ovf_d      = 1'b0;
      end else if (bit_en) begin
         sr_d = shifted[30:0];
         if (state_q == HUNT) begin
            if (shifted == SYNC_WORD) begin
               state_d    = PAYLOAD;
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
               // The slot is free if empty or being drained this very cycle.
               if (!valid_q || byte_ready) begin
                  byte_d  = shifted[7:0];
                  valid_d = 1'b1;
                  sof_d   = (byte_cnt_q == '0);
                  eof_d   = (byte_cnt_q == LAST_IDX);
               end else begin
                  ovf_d = 1'b1;
               end
               if (byte_cnt_q == LAST_IDX) begin
                  state_d    = HUNT;
                  byte_cnt_d = '0;
               end
            end
         end
      end else if (idle_expired) begin
         state_d    = HUNT;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         tmo_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q    <= HUNT;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         byte_q     <= '0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         ovf_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         ovf_q      <= ovf_d;
         tmo_q      <= tmo_d;
      end
   end

   assign byte_out    = byte_q;
   assign byte_valid  = valid_q;
   assign sof         = sof_q;
   assign eof         = eof_q;
   assign locked      = (state_q == PAYLOAD);
   assign overflow    = ovf_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Scoreboard bench for frame_sync_ctrl: a bit-level reference model predicts bytes and
// per-cycle flags; a negedge monitor compares them against the DUT.
module tb_frame_sync_ctrl;

   localparam logic [31:0] SYNC = 32'hEB90_146F;
   localparam int          FB   = 8;
   localparam int          TO   = 100;

   logic       clk = 1'b0;
   logic       nRST = 1'b0;
   logic       enable = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_en = 1'b0;
   logic       byte_ready = 1'b0;
   logic [7:0] byte_out;
   logic       byte_valid, sof, eof, locked, overflow, timeout_err;

   always #5 clk = ~clk;

   frame_sync_ctrl #(
      .SYNC_WORD   (SYNC),
      .FRAME_BYTES (FB),
      .IDLE_TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .nRST       (nRST),
      .enable     (enable),
      .bit_in     (bit_in),
      .bit_en     (bit_en),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .sof        (sof),
      .eof        (eof),
      .locked     (locked),
      .overflow   (overflow),
      .timeout_err(timeout_err)
   );

   typedef struct packed {logic [7:0] b; logic s; logic e;} exp_byte_t;
   typedef struct packed {logic lk; logic vld; logic ovf; logic tmo; logic rst;} exp_flag_t;

   exp_byte_t byte_q[$];
   exp_flag_t flag_q[$];
   bit        tx[$];
   int        total = 0;
   int        bad = 0;
   bit        mon_go = 0;

   // reference model state: bit history since last clear, position within frame
   bit          m_hunt = 1;
   logic [31:0] m_hist = '0;
   int          m_bits = 0, m_bytes = 0, m_idle = 0;
   bit          m_held = 0, m_ovf = 0, m_tmo = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      m_hunt = 1; m_hist = '0; m_bits = 0; m_bytes = 0; m_idle = 0;
      m_held = 0; m_ovf = 0; m_tmo = 0;
   endtask

   // Predicts the effect of the coming clock edge from the inputs just driven.
   task automatic step();
      exp_flag_t f;
      exp_byte_t e;
      bit        was_held, xfer;
      f = '0;
      if (!nRST) begin
         clear_model();
         byte_q.delete();
         f.rst = 1'b1;
         if (flag_q.size() > 0) flag_q[flag_q.size()-1] = f;
      end else if (!enable) begin
         xfer = m_held && byte_ready;
         if (!xfer) byte_q.delete();
         clear_model();
      end else begin
         was_held = m_held;
         xfer     = m_held && byte_ready;
         if (xfer) m_held = 0;
         m_tmo = 0;
         if (bit_en) begin
            m_hist = {m_hist[30:0], bit_in};
            m_idle = 0;
            if (m_hunt) begin
               if (m_hist == SYNC) begin
                  m_hunt = 0; m_bits = 0; m_bytes = 0;
               end
            end else begin
               m_bits++;
               if (m_bits == 8) begin
                  m_bits = 0;
                  e.b = m_hist[7:0];
                  e.s = (m_bytes == 0);
                  e.e = (m_bytes == FB - 1);
                  if (!was_held || byte_ready) begin
                     byte_q.push_back(e);
                     m_held = 1;
                  end else begin
                     m_ovf = 1;
                  end
                  m_bytes++;
                  if (e.e) begin
                     m_hunt = 1; m_bytes = 0;
                  end
               end
            end
         end else if (!m_hunt) begin
            if (m_idle == TO) begin
               m_tmo = 1; m_hunt = 1; m_bits = 0; m_bytes = 0; m_idle = 0;
            end else begin
               m_idle++;
            end
         end
      end
      f.lk  = !m_hunt;
      f.vld = m_held;
      f.ovf = m_ovf;
      f.tmo = m_tmo;
      flag_q.push_back(f);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) tx.push_back(w[i]);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) tx.push_back(b[i]);
   endtask

   task automatic push_frame();
      push_word(SYNC);
      for (int i = 0; i < FB; i++) push_byte(8'($urandom));
   endtask

   // rmode: 0 ready high, 1 random ready, 2 ready low
   task automatic run(input int n, input int pen, input int rmode);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         enable = 1'b1;
         nRST   = 1'b1;
         bit_en = 1'b0;
         bit_in = 1'($urandom);
         if (tx.size() > 0 && $urandom_range(99) < pen) begin
            bit_en = 1'b1;
            bit_in = tx.pop_front();
         end
         case (rmode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ($urandom_range(99) < 70);
            default: byte_ready = 1'b0;
         endcase
         step();
      end
   endtask

   task automatic en_off(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         enable     = 1'b0;
         bit_en     = 1'($urandom);
         bit_in     = 1'($urandom);
         byte_ready = 1'($urandom);
         step();
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         nRST   = 1'b0;
         bit_en = 1'b0;
         step();
      end
   endtask

   // Monitor: one flag expectation per cycle, one byte expectation per transfer.
   initial begin
      exp_flag_t f;
      exp_byte_t e;
      wait (mon_go);
      forever begin
         @(negedge clk);
         if (flag_q.size() == 0) begin
            total++; bad++;
            $display("FAIL flag_queue: got empty expected entry at %0t", $time);
         end else begin
            f = flag_q.pop_front();
            chk("locked", 32'(locked), 32'(f.lk));
            chk("byte_valid", 32'(byte_valid), 32'(f.vld));
            chk("overflow", 32'(overflow), 32'(f.ovf));
            chk("timeout_err", 32'(timeout_err), 32'(f.tmo));
            if (f.rst) begin
               chk("rst_byte_out", 32'(byte_out), 32'h0);
               chk("rst_sof", 32'(sof), 32'h0);
               chk("rst_eof", 32'(eof), 32'h0);
            end
         end
         if (byte_valid && byte_ready) begin
            if (byte_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_byte: got %0h expected none at %0t", byte_out, $time);
            end else begin
               e = byte_q.pop_front();
               $display("xfer byte=%02h sof=%0b eof=%0b t=%0t", byte_out, sof, eof, $time);
               chk("byte_out", 32'(byte_out), 32'(e.b));
               chk("sof", 32'(sof), 32'(e.s));
               chk("eof", 32'(eof), 32'(e.e));
            end
         end
      end
   end

   initial begin
      nRST = 1'b0;
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_locked", 32'(locked), 32'h0);
      chk("reset_valid", 32'(byte_valid), 32'h0);
      chk("reset_overflow", 32'(overflow), 32'h0);
      chk("reset_timeout", 32'(timeout_err), 32'h0);
      chk("reset_byte_out", 32'(byte_out), 32'h0);
      chk("reset_sof", 32'(sof), 32'h0);
      chk("reset_eof", 32'(eof), 32'h0);

      flag_q.push_back(exp_flag_t'(5'b00001));
      mon_go = 1;
      nRST = 1'b1;
      step();

      // near-miss pattern then the real sync word and one frame
      push_word(32'hEB90_146E);
      push_frame();
      run(140, 100, 0);

      // backpressure across two completed bytes
      push_word(SYNC);
      push_byte(8'hA5);
      push_byte(8'h3C);
      for (int i = 0; i < FB - 2; i++) push_byte(8'($urandom));
      run(55, 100, 2);
      run(60, 100, 0);
      en_off(3);

      // idle timeout after three payload bits
      push_word(SYNC);
      tx.push_back(1'b1); tx.push_back(1'b0); tx.push_back(1'b1);
      run(40, 100, 0);
      run(150, 100, 0);

      // payload carrying the sync pattern must not relock
      push_word(SYNC);
      push_word(SYNC);
      push_word(SYNC);
      run(120, 100, 0);

      // reset mid-frame, leftover bits alone must not produce output
      push_frame();
      run(60, 100, 0);
      do_reset(2);
      run(60, 100, 0);
      push_frame();
      run(120, 100, 1);

      // randomized traffic
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(99) < 70) push_frame();
         else for (int i = 0; i < $urandom_range(40, 1); i++) tx.push_back(1'($urandom));
         if ($urandom_range(99) < 20) push_word(SYNC);
         run($urandom_range(300, 100), $urandom_range(100, 20), 1);
         if ($urandom_range(99) < 20) en_off($urandom_range(4, 1));
         if ($urandom_range(99) < 10) run(130, 0, 1);
      end

      tx.delete();
      run(40, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("drain_pending", 32'(byte_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
